route_demux: RTL

- Registered 1-to-2 routing demultiplexer: the counterpart of the 2-to-1 routing mux, fanning one logic-box output out to one of two destinations.
- Steers a valid/ready data stream to output O0 or O1.
- Route select is held in a config register. The register resets to the FASM default and can be reloaded at runtime through a 2-bit serial config chain.
- Sits between a logic box output and two downstream consumers in routing-fabric test designs.

---
 rtl/route_demux.sv | 133 +++++++++++++
 1 files changed

// File: rtl/route_demux.sv
// Registered 1-to-2 routing demultiplexer: steers a valid/ready stream to O0 or O1
// through a shared FIFO; route select is reloaded via a 2-bit serial config chain.
`timescale 1ns/1ps

module route_demux #(
  parameter int WIDTH      = 1,
  parameter bit FASM_DEMUX = 1'b0,
  parameter int DEPTH      = 2
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic [WIDTH-1:0] I,
  input  logic             I_VALID,
  output logic             I_READY,
  output logic [WIDTH-1:0] O0,
  output logic             O0_VALID,
  input  logic             O0_READY,
  output logic [WIDTH-1:0] O1,
  output logic             O1_VALID,
  input  logic             O1_READY,
  input  logic             CFG_EN,
  input  logic             CFG_DIN,
  output logic             CFG_DOUT,
  output logic             SEL
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef enum logic [1:0] {
    RUN    = 2'd0,
    DRAIN  = 2'd1,
    COMMIT = 2'd2
  } state_t;

  state_t           state, state_next;
  logic [WIDTH-1:0] data_mem [DEPTH];
  logic             tag_mem  [DEPTH];
  logic [PW-1:0]    rd_ptr, wr_ptr;
  logic [CW-1:0]    count;
  logic [1:0]       shadow;
  logic             sel_q;
  logic             push, pop, empty, commit;
  logic             head_tag;
  logic [WIDTH-1:0] head_data;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign empty     = (count == '0);
  assign head_data = data_mem[rd_ptr];
  assign head_tag  = tag_mem[rd_ptr];
  assign push      = I_VALID && I_READY;
  // Only the destination named by the head tag can pop; the other READY is ignored.
  assign pop       = !empty && (head_tag ? O1_READY : O0_READY);

  // NOTE: the FIFO storage has no reset; every output is gated by count, so stale
  // entries are never visible and the array maps onto plain flops/LUT-RAM.
  always_ff @(posedge CLK) begin
    if (push) begin
      data_mem[wr_ptr] <= I;
      tag_mem[wr_ptr]  <= sel_q;
    end
  end

  // NOTE: all sequential state uses non-blocking assignments so every register
  // samples the pre-edge values of the others.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= ptr_inc(wr_ptr);
      if (pop)  rd_ptr <= ptr_inc(rd_ptr);
      unique case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) state <= RUN;
    else        state <= state_next;
  end

  // NOTE: each always_comb assigns its outputs a default first so no latch is inferred.
  always_comb begin
    state_next = state;
    unique case (state)
      RUN:    if (!CFG_EN && shadow[1]) state_next = DRAIN;
      DRAIN: begin
        if (!shadow[1])  state_next = RUN;     // pending cleared by a shift: abort
        else if (empty)  state_next = COMMIT;
      end
      COMMIT: state_next = RUN;
      default: state_next = RUN;
    endcase
  end

  always_comb begin
    I_READY = 1'b0;
    commit  = 1'b0;
    if (state == RUN && count < CW'(DEPTH)) I_READY = 1'b1;
    if (state == COMMIT)                    commit  = 1'b1;
  end

  // A shift in the commit cycle wins over clearing PENDING.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      shadow <= {1'b0, FASM_DEMUX};
      sel_q  <= FASM_DEMUX;
    end else begin
      if (CFG_EN)      shadow    <= {CFG_DIN, shadow[1]};
      else if (commit) shadow[1] <= 1'b0;
      if (commit)      sel_q     <= shadow[0];
    end
  end

  always_comb begin
    O0_VALID = !empty && !head_tag;
    O1_VALID = !empty && head_tag;
    O0       = O0_VALID ? head_data : '0;
    O1       = O1_VALID ? head_data : '0;
  end

  assign CFG_DOUT = shadow[0];
  assign SEL      = sel_q;

endmodule
